div_unit: RTL and testbench

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_unit.sv | 158 +++++++++++++++
 tb/tb_div_unit.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU, 32 steps, 34-cycle latency.
// Ports: clk_i, rst_i (async, active high); div_start_i, div_op_i, dividend_i,
//   divisor_i, div_flush_i in; div_result_o, div_res_ready_o, div_busy_o out.
// Optional: define DIV_FAST_SPECIAL_EN to finish divide-by-zero and signed
//   overflow in 2 cycles instead of running all 32 steps.
`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif

module div_unit (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  div_start_i,
  input  logic [1:0]            div_op_i,
  input  logic [`CPU_WIDTH-1:0] dividend_i,
  input  logic [`CPU_WIDTH-1:0] divisor_i,
  input  logic                  div_flush_i,
  output logic [`CPU_WIDTH-1:0] div_result_o,
  output logic                  div_res_ready_o,
  output logic                  div_busy_o
);

  localparam int W  = `CPU_WIDTH;
  localparam int CW = $clog2(W) + 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t         state_q, state_d;
  logic [1:0]     op_q;
  logic [W-1:0]   dvd_q, dsr_q, quo_q, rem_q, res_q;
  logic [CW-1:0]  cnt_q;
  logic           neg_quo_q, neg_rem_q, dz_q, ovf_q, rdy_q;

  logic           is_signed, a_neg, b_neg;
  logic [W-1:0]   a_mag, b_mag;
  logic           dz, ovf, special, accept;
  logic [W:0]     shifted, diff;
  logic           q_bit;
  logic [W-1:0]   quo_fix, rem_fix, result;

  assign is_signed = ~div_op_i[0];
  assign a_neg     = is_signed & dividend_i[W-1];
  assign b_neg     = is_signed & divisor_i[W-1];
  assign a_mag     = a_neg ? (W'(0) - dividend_i) : dividend_i;
  assign b_mag     = b_neg ? (W'(0) - divisor_i) : divisor_i;

  assign dz      = (divisor_i == '0);
  assign ovf     = is_signed
                 & (dividend_i == {1'b1, {(W-1){1'b0}}})
                 & (divisor_i == '1);
  assign special = dz | ovf;

  // The ready cycle is an IDLE cycle; a start still held from the finished
  // request must not be taken as a new one.
  assign accept  = div_start_i & ~div_flush_i & ~rdy_q;

  // Restoring step: shifted is never wider than W+1 bits, so bit W of the
  // difference is the borrow.
  assign shifted = {rem_q, dvd_q[W-1]};
  assign diff    = shifted - {1'b0, dsr_q};
  assign q_bit   = ~diff[W];

  always_comb begin
    quo_fix = neg_quo_q ? (W'(0) - quo_q) : quo_q;
    rem_fix = neg_rem_q ? (W'(0) - rem_q) : rem_q;
    if (dz_q) begin
      quo_fix = '1;
    end
    if (ovf_q) begin
      quo_fix = {1'b1, {(W-1){1'b0}}};
      rem_fix = '0;
    end
    result = op_q[1] ? rem_fix : quo_fix;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
`ifdef DIV_FAST_SPECIAL_EN
          state_d = special ? DONE : CALC;
`else
          state_d = CALC;
`endif
        end
      end
      CALC: begin
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (div_flush_i) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      op_q      <= '0;
      dvd_q     <= '0;
      dsr_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      res_q     <= '0;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      ovf_q     <= 1'b0;
      rdy_q     <= 1'b0;
    end else begin
      rdy_q <= 1'b0;
      if (state_q == IDLE && accept) begin
        op_q      <= div_op_i;
        dvd_q     <= a_mag;
        dsr_q     <= b_mag;
        neg_quo_q <= a_neg ^ b_neg;
        neg_rem_q <= a_neg;
        dz_q      <= dz;
        ovf_q     <= ovf;
        quo_q     <= '0;
        rem_q     <= '0;
        cnt_q     <= CW'(W);
`ifdef DIV_FAST_SPECIAL_EN
        // Skipped steps would leave the dividend magnitude here.
        if (special) begin
          rem_q <= a_mag;
        end
`endif
      end else if (state_q == CALC) begin
        dvd_q <= {dvd_q[W-2:0], 1'b0};
        quo_q <= {quo_q[W-2:0], q_bit};
        rem_q <= q_bit ? diff[W-1:0] : shifted[W-1:0];
        cnt_q <= cnt_q - CW'(1);
      end else if (state_q == DONE && !div_flush_i) begin
        res_q <= result;
        rdy_q <= 1'b1;
      end
    end
  end

  assign div_result_o    = res_q;
  assign div_res_ready_o = rdy_q;
  assign div_busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: directed corner cases plus random ops
// against an arithmetic reference model; flush and mid-operation reset.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op_i = 2'd0;
  logic [31:0] dvd = '0;
  logic [31:0] dsr = '0;
  logic        flush = 1'b0;
  logic [31:0] result;
  logic        ready;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] res;
    int          acc;
    int          lat;
    string       nm;
  } exp_t;

  exp_t scb[$];

  div_unit dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .div_start_i    (start),
    .div_op_i       (op_i),
    .dividend_i     (dvd),
    .divisor_i      (dsr),
    .div_flush_i    (flush),
    .div_result_o   (result),
    .div_res_ready_o(ready),
    .div_busy_o     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  function automatic logic [31:0] ref_div(input logic [1:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = a;
    sb = b;
    if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return op[1] ? 32'h0 : 32'h8000_0000;
    case (op)
      2'd0:    return sa / sb;
      2'd1:    return a / b;
      2'd2:    return sa % sb;
      default: return a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [1:0] op,
                                 input logic [31:0] a,
                                 input logic [31:0] b);
    logic sp;
    sp = (b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
`ifdef DIV_FAST_SPECIAL_EN
    return sp ? 2 : 34;
`else
    return sp ? 34 : 34;
`endif
  endfunction

  // Monitor: every ready pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (!rst && ready) begin
      n_cmp++;
      if (scb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_ready got=%h", result);
      end else begin
        exp_t e;
        e = scb.pop_front();
        if (result !== e.res || (cyc - e.acc) != e.lat - 1) begin
          n_bad++;
          $display("FAIL %s got=%h lat=%0d want=%h lat=%0d",
                   e.nm, result, cyc - e.acc + 1, e.res, e.lat);
        end
      end
    end
  end

  task automatic push(input logic [1:0] op, input logic [31:0] a,
                      input logic [31:0] b, input string nm);
    exp_t e;
    e.res = ref_div(op, a, b);
    e.lat = ref_lat(op, a, b);
    e.acc = cyc;
    e.nm  = nm;
    scb.push_back(e);
  endtask

  task automatic launch(input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input string nm);
    @(negedge clk);
    start = 1'b1;
    op_i  = op;
    dvd   = a;
    dsr   = b;
    @(posedge clk);
    #1;
    push(op, a, b, nm);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL busy_after_start %s got=%b want=1", nm, busy);
    end
  endtask

  task automatic wait_done(input bit scramble);
    bit seen;
    seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (ready) begin
        seen = 1;
      end else if (scramble) begin
        dvd  = $urandom;
        dsr  = $urandom;
        op_i = 2'($urandom_range(0, 3));
      end
    end
    start = 1'b0;
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout got=no_ready want=ready");
    end
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    string       nm;
  } vec_t;

  vec_t dir[$];

  initial begin
    dir.push_back('{2'd1, 32'd100, 32'd7, "divu_100_7"});
    dir.push_back('{2'd3, 32'd100, 32'd7, "remu_100_7"});
    dir.push_back('{2'd0, 32'hFFFF_FFF9, 32'd2, "div_m7_2"});
    dir.push_back('{2'd2, 32'hFFFF_FFF9, 32'd2, "rem_m7_2"});
    dir.push_back('{2'd0, 32'd7, 32'hFFFF_FFFE, "div_7_m2"});
    dir.push_back('{2'd2, 32'd7, 32'hFFFF_FFFE, "rem_7_m2"});
    dir.push_back('{2'd0, 32'd5, 32'd0, "div_5_0"});
    dir.push_back('{2'd3, 32'd5, 32'd0, "remu_5_0"});
    dir.push_back('{2'd2, 32'hFFFF_FFFB, 32'd0, "rem_m5_0"});
    dir.push_back('{2'd0, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf"});
    dir.push_back('{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf"});
    dir.push_back('{2'd1, 32'hFFFF_FFFF, 32'd1, "divu_max_1"});

    #1;
    n_cmp++;
    if (result !== 32'h0 || ready !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state got=%h/%b/%b want=0/0/0",
               result, ready, busy);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;

    foreach (dir[i]) begin
      launch(dir[i].op, dir[i].a, dir[i].b, dir[i].nm);
      wait_done(1);
    end

    // Flush in the 10th CALC cycle.
    launch(2'd1, 32'd1000, 32'd3, "flushed");
    void'(scb.pop_back());
    repeat (10) @(negedge clk);
    start = 1'b0;
    flush = 1'b1;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL busy_before_flush got=%b want=1", busy);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL busy_after_flush got=%b want=0", busy);
    end
    @(negedge clk);
    flush = 1'b0;
    repeat (40) @(negedge clk);
    launch(2'd1, 32'd9, 32'd3, "divu_9_3");
    wait_done(1);

    // Asynchronous reset in the middle of CALC, start held through it.
    launch(2'd0, 32'hFFFF_FF9C, 32'd7, "pre_reset");
    void'(scb.pop_back());
    repeat (5) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (result !== 32'h0 || ready !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL async_reset got=%h/%b/%b want=0/0/0",
               result, ready, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    push(2'd0, 32'hFFFF_FF9C, 32'd7, "after_reset");
    wait_done(1);

    for (int k = 0; k < 40; k++) begin
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      int          mode;
      op   = 2'($urandom_range(0, 3));
      a    = $urandom;
      b    = $urandom;
      mode = $urandom_range(0, 9);
      if (mode == 0) b = 32'd0;
      if (mode == 1) begin
        a = 32'h8000_0000;
        b = 32'hFFFF_FFFF;
      end
      if (mode == 2) b = $urandom_range(1, 15);
      if (mode == 3) a = $urandom_range(0, 100);
      launch(op, a, b, "random");
      wait_done(1);
    end

    repeat (5) @(negedge clk);
    n_cmp++;
    if (scb.size() != 0) begin
      n_bad++;
      $display("FAIL drain got=%0d pending want=0", scb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
